// File: rtl/tybec_stream_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tybec_stream_run_ctrl_if
// Description : Handshake bundle for tybec_stream_run_ctrl. Groups the run
//               control (ap_*), the per-channel input streams (s_*), the
//               kernel-facing join/backpressure pair (k_*) and the output
//               stream flags (m_*).
//   slave  : the run controller's view
//   master : the view of whatever drives the controller (shell + kernel)
// Revision    : 1.0 - initial release
// ============================================================================
interface tybec_stream_run_ctrl_if #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_LEN_WIDTH    = 32
);
  // run control
  logic                                   ap_start;
  logic [C_LEN_WIDTH-1:0]                 ap_len;
  logic                                   ap_busy;
  logic                                   ap_done;
  // input streams, channel i at bits [i*C_DATA_WIDTH +: C_DATA_WIDTH]
  logic [C_NUM_CHANNELS-1:0]              s_tvalid;
  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] s_tdata;
  logic [C_NUM_CHANNELS-1:0]              s_tready;
  // kernel side
  logic                                   k_ivalid;
  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] k_idata;
  logic                                   k_iready;
  logic                                   k_ovalid;
  logic                                   k_oready;
  // output stream flags (data bypasses the controller)
  logic                                   m_tvalid;
  logic                                   m_tlast;
  logic                                   m_tready;

  modport slave (
    input  ap_start, ap_len, s_tvalid, s_tdata, k_iready, k_ovalid, m_tready,
    output ap_busy, ap_done, s_tready, k_ivalid, k_idata, k_oready, m_tvalid, m_tlast
  );

  modport master (
    output ap_start, ap_len, s_tvalid, s_tdata, k_iready, k_ovalid, m_tready,
    input  ap_busy, ap_done, s_tready, k_ivalid, k_idata, k_oready, m_tvalid, m_tlast
  );
endinterface
`default_nettype wire

// File: rtl/tybec_stream_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tybec_stream_run_ctrl
// Description : Run controller between an AXI-stream shell and a TyBEC kernel
//               pipeline. Each input channel feeds a 2-deep FIFO; the FIFO
//               heads are joined into one ivalid/iready handshake. A run is
//               bounded to ap_len items; the last output beat is flagged with
//               m_tlast and ap_done pulses once every output has left.
// Ports       : aclk, areset_n     clock, asynchronous active-low reset
//               bus (slave)        ap_* run control, s_* input streams,
//                                  k_* kernel handshake, m_* output flags
// Revision    : 1.0 - initial release
// ============================================================================
module tybec_stream_run_ctrl #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_LEN_WIDTH    = 32
) (
  input  wire logic                 aclk,
  input  wire logic                 areset_n,
  tybec_stream_run_ctrl_if.slave    bus
);

  localparam logic [C_LEN_WIDTH-1:0] C_ONE = C_LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [C_LEN_WIDTH-1:0]  r_len_q;
  logic [C_LEN_WIDTH-1:0]  r_issue_cnt;
  logic [C_LEN_WIDTH-1:0]  r_out_cnt;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_run;
  logic                    w_active;
  logic                    w_start;
  logic                    w_k_ivalid;
  logic                    w_issue;
  logic                    w_issue_last;
  logic                    w_m_tvalid;
  logic                    w_out;
  logic                    w_out_last;
  logic [C_LEN_WIDTH-1:0]  w_len_m1;
  logic [C_NUM_CHANNELS-1:0] w_nonempty;
  logic [C_NUM_CHANNELS-1:0] w_ready;
  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] w_k_idata;

  assign w_run    = (r_state == S_RUN);
  assign w_active = (r_state == S_RUN) | (r_state == S_DRAIN);
  // Counters and FIFOs are cleared only when a non-empty run actually begins.
  assign w_start  = (r_state == S_IDLE) & bus.ap_start & (bus.ap_len != '0);
  assign w_len_m1 = r_len_q - C_ONE;

  // Join: the kernel sees a valid item only when every channel has a head.
  assign w_k_ivalid   = w_run & (&w_nonempty);
  assign w_issue      = w_k_ivalid & bus.k_iready;
  assign w_issue_last = w_issue & (r_issue_cnt == w_len_m1);

  // Output side is a pure gate on the kernel handshake; the sink's ready
  // never reaches the input side.
  assign w_m_tvalid = bus.k_ovalid & w_active;
  assign w_out      = w_m_tvalid & bus.m_tready;
  assign w_out_last = w_out & (r_out_cnt == w_len_m1);

  assign bus.ap_busy  = r_busy;
  assign bus.ap_done  = r_done;
  assign bus.s_tready = w_ready;
  assign bus.k_ivalid = w_k_ivalid;
  assign bus.k_idata  = w_k_idata;
  assign bus.k_oready = bus.m_tready & w_active;
  assign bus.m_tvalid = w_m_tvalid;
  assign bus.m_tlast  = w_m_tvalid & (r_out_cnt == w_len_m1);

  // --------------------------------------------------------------------------
  // Run FSM. ap_busy/ap_done are registered alongside the state so they track
  // it exactly (busy in RUN/DRAIN, done in DONE).
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= S_IDLE;
      r_len_q     <= '0;
      r_issue_cnt <= '0;
      r_out_cnt   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            if (bus.ap_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_RUN;
              r_busy      <= 1'b1;
              r_len_q     <= bus.ap_len;
              r_issue_cnt <= '0;
              r_out_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          if (w_issue) r_issue_cnt <= r_issue_cnt + C_ONE;
          if (w_out)   r_out_cnt   <= r_out_cnt + C_ONE;
          if (w_issue_last) begin
            // The last output can leave in the same cycle as the last issue
            // only for a zero-latency kernel; skip DRAIN in that case.
            if (w_out_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_out) r_out_cnt <= r_out_cnt + C_ONE;
          if (w_out_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel 2-deep FIFO and accepted-beat counter. Ready needs a free slot,
  // so a push never meets a full FIFO; a pop always comes from a non-empty one.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < C_NUM_CHANNELS; gi++) begin : g_chan
    logic [C_DATA_WIDTH-1:0] r_mem0;
    logic [C_DATA_WIDTH-1:0] r_mem1;
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic [C_LEN_WIDTH-1:0]  r_acc_cnt;
    logic                    w_push;

    assign w_ready[gi]    = w_run & (r_count != 2'd2) & (r_acc_cnt < r_len_q);
    assign w_push         = bus.s_tvalid[gi] & w_ready[gi];
    assign w_nonempty[gi] = (r_count != 2'd0);
    assign w_k_idata[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = r_rd_ptr ? r_mem1 : r_mem0;

    always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
        r_mem0    <= '0;
        r_mem1    <= '0;
        r_wr_ptr  <= 1'b0;
        r_rd_ptr  <= 1'b0;
        r_count   <= 2'd0;
        r_acc_cnt <= '0;
      end else if (w_start) begin
        r_wr_ptr  <= 1'b0;
        r_rd_ptr  <= 1'b0;
        r_count   <= 2'd0;
        r_acc_cnt <= '0;
      end else begin
        if (w_push) begin
          if (r_wr_ptr) r_mem1 <= bus.s_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
          else          r_mem0 <= bus.s_tdata[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
          r_wr_ptr  <= ~r_wr_ptr;
          r_acc_cnt <= r_acc_cnt + C_ONE;
        end
        if (w_issue) r_rd_ptr <= ~r_rd_ptr;
        case ({w_push, w_issue})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
